// File: rtl/i2c_txn_arbiter_if.sv
// i2c_arb_if: requester and I2C-master signal bundle for i2c_txn_arbiter
interface i2c_arb_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0] req;
  logic [7*NUM_REQ-1:0] req_addr;
  logic [NUM_REQ-1:0] req_rw;
  logic [8*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] done;
  logic err;
  logic [7:0] rdata;
  logic m_enable;
  logic [6:0] m_addr;
  logic m_rw;
  logic [7:0] m_wdata;
  logic [7:0] m_rdata;
  logic m_ready;
  modport slave (
    input req, req_addr, req_rw, req_wdata, m_rdata, m_ready,
    output gnt, done, err, rdata, m_enable, m_addr, m_rw, m_wdata
  );
  modport master (
    output req, req_addr, req_rw, req_wdata, m_rdata, m_ready,
    input gnt, done, err, rdata, m_enable, m_addr, m_rw, m_wdata
  );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin sharing of one I2C master with watchdog abort; I2C_ARB_FIXED_PRIO_EN selects fixed priority
module i2c_txn_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TW = 12
) (
  input logic clk,
  input logic rst,
  i2c_arb_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [1:0] IDLE = 2'd0, LAUNCH = 2'd1, BUSY = 2'd2, DONE = 2'd3;
  localparam logic [TW-1:0] WD_MAX = TW'(TIMEOUT_CYCLES - 1);
  logic [1:0] state;
  logic [TW-1:0] wd;
  logic rdy_q, rdy_s, abort, grant, wd_hit;
  logic [PW-1:0] win;
  logic [NUM_REQ-1:0] gnt;
  logic [7:0] rdata, m_wdata;
  logic [6:0] m_addr;
  logic m_enable, m_rw;
  assign grant = state == IDLE && rdy_s && |bus.req;
  assign wd_hit = wd == WD_MAX;
`ifdef I2C_ARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) win = bus.req[k] ? PW'(k) : win;
  end
`else
  localparam logic [PW:0] NR = (PW+1)'(NUM_REQ);
  logic [PW-1:0] ptr;
  logic [PW:0] sum, idx;
  logic found;
  // first set request at or after ptr, wrapping at NUM_REQ
  always_comb begin
    win = '0;
    found = 1'b0;
    sum = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      idx = sum >= NR ? sum - NR : sum;
      if (!found && bus.req[idx]) begin
        win = idx[PW-1:0];
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (grant) ptr <= win == PW'(NUM_REQ - 1) ? '0 : win + 1'b1;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rdy_q <= 1'b0;
      rdy_s <= 1'b0;
      state <= IDLE;
      wd <= '0;
      abort <= 1'b0;
      gnt <= '0;
      rdata <= '0;
      m_enable <= 1'b0;
      m_addr <= '0;
      m_rw <= 1'b0;
      m_wdata <= '0;
    end else begin
      rdy_q <= bus.m_ready;
      rdy_s <= rdy_q;
      case (state)
        IDLE: if (grant) begin
          gnt <= NUM_REQ'(1) << win;
          m_addr <= bus.req_addr[7*win +: 7];
          m_rw <= bus.req_rw[win];
          m_wdata <= bus.req_wdata[8*win +: 8];
          m_enable <= 1'b1;
          wd <= '0;
          state <= LAUNCH;
        end
        LAUNCH: if (!rdy_s) begin
          m_enable <= 1'b0;
          wd <= '0;
          state <= BUSY;
        end else if (wd_hit) begin
          m_enable <= 1'b0;
          abort <= 1'b1;
          state <= DONE;
        end else wd <= wd + 1'b1;
        // enable stays low here so the master finishes with a STOP
        BUSY: if (rdy_s) begin
          if (m_rw) rdata <= bus.m_rdata;
          state <= DONE;
        end else if (wd_hit) begin
          abort <= 1'b1;
          state <= DONE;
        end else wd <= wd + 1'b1;
        default: begin
          gnt <= '0;
          abort <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  assign bus.gnt = gnt;
  assign bus.done = state == DONE ? gnt : '0;
  assign bus.err = state == DONE && abort;
  assign bus.rdata = rdata;
  assign bus.m_enable = m_enable;
  assign bus.m_addr = m_addr;
  assign bus.m_rw = m_rw;
  assign bus.m_wdata = m_wdata;
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb_i2c_txn_arbiter: randomized and directed checks of i2c_txn_arbiter against a transaction-level model
module tb_i2c_txn_arbiter;
  localparam int N = 4;
  localparam int T = 16;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  i2c_arb_if #(.NUM_REQ(N)) bus();
  i2c_txn_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T), .TW(12)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int passed = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  // master model: mode 0 normal, 1 never starts, 2 never finishes
  int mode = 0;
  bit mbusy = 0;
  int dly = 0, cnt = 0;
  bit fix_en = 0;
  logic [7:0] fix_val = 8'h00;
  initial begin
    bus.m_ready = 1'b1;
    bus.m_rdata = 8'h00;
  end
  always @(negedge clk) begin
    if (rst) begin
      bus.m_ready = 1'b1;
      mbusy = 0;
      dly = $urandom_range(0, 3);
    end else if (mode == 1) begin
      bus.m_ready = 1'b1;
      mbusy = 0;
    end else if (!mbusy) begin
      if (bus.m_enable) begin
        if (dly == 0) begin
          bus.m_ready = 1'b0;
          mbusy = 1;
          cnt = $urandom_range(3, 8);
        end else dly--;
      end else dly = $urandom_range(0, 3);
    end else if (mode == 0) begin
      if (cnt == 0) begin
        bus.m_ready = 1'b1;
        bus.m_rdata = fix_en ? fix_val : 8'($urandom);
        mbusy = 0;
        dly = $urandom_range(0, 3);
      end else cnt--;
    end
  end
  // reference model: one outstanding transaction, winner chosen by rule
  bit act, launched, fin, ab, m_rs;
  int w, mptr, cyc, t0;
  logic [1:0] sr;
  logic [6:0] e_addr;
  logic e_rw;
  logic [7:0] e_wdata, e_rdata;
  function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef I2C_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int j = 0; j < N; j++) if (r[(p + j) % N]) return (p + j) % N;
`endif
    return 0;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      act = 0; launched = 0; fin = 0; ab = 0; w = 0; mptr = 0; cyc = 0; t0 = 0;
      sr = 2'b00; e_addr = '0; e_rw = 1'b0; e_wdata = '0; e_rdata = '0;
    end else begin
      m_rs = sr[1];
      sr = {sr[0], bus.m_ready};
      cyc++;
      if (fin) begin
        act = 0; fin = 0; ab = 0;
      end else if (act && !launched) begin
        if (!m_rs) begin launched = 1; t0 = cyc; end
        else if (cyc - t0 == T) begin fin = 1; ab = 1; end
      end else if (act) begin
        if (m_rs) begin fin = 1; if (e_rw) e_rdata = bus.m_rdata; end
        else if (cyc - t0 == T) begin fin = 1; ab = 1; end
      end else if (m_rs && bus.req != '0) begin
        w = pick(bus.req, mptr);
        mptr = (w + 1) % N;
        act = 1; launched = 0; t0 = cyc;
        e_addr = bus.req_addr[7*w +: 7];
        e_rw = bus.req_rw[w];
        e_wdata = bus.req_wdata[8*w +: 8];
      end
    end
  end
  always @(negedge clk) if (!rst) begin
    chk("gnt", 32'(bus.gnt), act ? 32'(1) << w : 32'd0);
    chk("done", 32'(bus.done), fin ? 32'(1) << w : 32'd0);
    chk("err", 32'(bus.err), 32'(fin && ab));
    chk("m_enable", 32'(bus.m_enable), 32'(act && !launched && !fin));
    chk("m_addr", 32'(bus.m_addr), 32'(e_addr));
    chk("m_rw", 32'(bus.m_rw), 32'(e_rw));
    chk("m_wdata", 32'(bus.m_wdata), 32'(e_wdata));
    chk("rdata", 32'(bus.rdata), 32'(e_rdata));
  end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask
  task automatic set_req(input int i, input logic [6:0] a, input logic rw, input logic [7:0] d);
    bus.req_addr[7*i +: 7] = a;
    bus.req_rw[i] = rw;
    bus.req_wdata[8*i +: 8] = d;
  endtask
  task automatic wait_gnt();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (bus.gnt != '0) begin ok = 1; break; end
      tick();
    end
    chk("wait_gnt", 32'(ok), 32'd1);
  endtask
  task automatic wait_done(output int n);
    bit ok = 0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (bus.done != '0) begin ok = 1; break; end
      tick();
      n++;
    end
    chk("wait_done", 32'(ok), 32'd1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, order[5];
    rst = 1'b1;
    bus.req = '0; bus.req_addr = '0; bus.req_rw = '0; bus.req_wdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_en", 32'(bus.m_enable), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    // single write
    set_req(0, 7'h50, 1'b0, 8'hA5);
    bus.req = 4'b0001;
    wait_gnt();
    chk("wr_gnt", 32'(bus.gnt), 32'h1);
    chk("wr_addr", 32'(bus.m_addr), 32'h50);
    chk("wr_wdata", 32'(bus.m_wdata), 32'hA5);
    chk("wr_en", 32'(bus.m_enable), 32'd1);
    wait_done(n);
    chk("wr_done", 32'(bus.done), 32'h1);
    chk("wr_err", 32'(bus.err), 32'd0);
    chk("wr_rdata", 32'(bus.rdata), 32'h00);
    bus.req = '0;
    tick();
    chk("wr_done_once", 32'(bus.done), 32'd0);
    chk("wr_gnt_clr", 32'(bus.gnt), 32'd0);
    // single read
    fix_en = 1; fix_val = 8'h5A;
    set_req(2, 7'h3C, 1'b1, 8'h00);
    bus.req = 4'b0100;
    wait_gnt();
    chk("rd_gnt", 32'(bus.gnt), 32'h4);
    chk("rd_addr", 32'(bus.m_addr), 32'h3C);
    wait_done(n);
    chk("rd_done", 32'(bus.done), 32'h4);
    chk("rd_rdata", 32'(bus.rdata), 32'h5A);
    bus.req = '0;
    // contention from a fresh pointer
    do_reset();
    bus.req_rw = '0;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt();
      order[k] = 0;
      for (int i = 0; i < N; i++) if (bus.gnt[i]) order[k] = i;
      wait_done(n);
      tick();
    end
    bus.req = '0;
    for (int k = 0; k < 5; k++) begin
`ifdef I2C_ARB_FIXED_PRIO_EN
      chk($sformatf("order%0d", k), 32'(order[k]), 32'd0);
`else
      chk($sformatf("order%0d", k), 32'(order[k]), 32'(k % N));
`endif
    end
    // launch timeout
    do_reset();
    mode = 1;
    set_req(1, 7'h21, 1'b1, 8'h00);
    bus.req = 4'b0010;
    wait_gnt();
    wait_done(n);
    chk("lto_cycles", 32'(n), 32'd16);
    chk("lto_done", 32'(bus.done), 32'h2);
    chk("lto_err", 32'(bus.err), 32'd1);
    chk("lto_en", 32'(bus.m_enable), 32'd0);
    chk("lto_rdata", 32'(bus.rdata), 32'h00);
    bus.req = '0;
    mode = 0;
    repeat (4) tick();
    // busy timeout then recovery
    mode = 2;
    set_req(0, 7'h11, 1'b0, 8'h22);
    bus.req = 4'b0001;
    wait_gnt();
    wait_done(n);
    chk("bto_done", 32'(bus.done), 32'h1);
    chk("bto_err", 32'(bus.err), 32'd1);
    repeat (10) tick();
    chk("bto_hold", 32'(bus.gnt), 32'd0);
    mode = 0;
    wait_gnt();
    chk("bto_regnt", 32'(bus.gnt), 32'h1);
    wait_done(n);
    chk("bto_ok", 32'(bus.err), 32'd0);
    bus.req = '0;
    tick();
    // reset during a read
    fix_val = 8'h77;
    set_req(0, 7'h2A, 1'b1, 8'h00);
    bus.req = 4'b0001;
    wait_gnt();
    wait_done(n);
    chk("mr_first", 32'(bus.rdata), 32'h77);
    bus.req = '0;
    tick();
    fix_val = 8'h99;
    bus.req = 4'b0001;
    wait_gnt();
    for (int i = 0; i < 50 && bus.m_enable; i++) tick();
    chk("mr_in_busy", 32'(bus.m_enable), 32'd0);
    rst = 1'b1;
    #1;
    chk("mr_gnt", 32'(bus.gnt), 32'd0);
    chk("mr_en", 32'(bus.m_enable), 32'd0);
    chk("mr_done", 32'(bus.done), 32'd0);
    chk("mr_rdata", 32'(bus.rdata), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    wait_gnt();
    wait_done(n);
    chk("mr_after_done", 32'(bus.done), 32'h1);
    chk("mr_after_err", 32'(bus.err), 32'd0);
    chk("mr_after_rdata", 32'(bus.rdata), 32'h99);
    bus.req = '0;
    // randomized traffic
    fix_en = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 7) == 0) bus.req = N'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        bus.req_addr = 28'($urandom);
        bus.req_rw = N'($urandom);
        bus.req_wdata = $urandom;
      end
      if (c % 250 == 249) mode = $urandom_range(0, 5) > 3 ? $urandom_range(1, 2) : 0;
    end
    mode = 0;
    bus.req = '0;
    repeat (60) tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
